// File: rtl/score_display_scan.sv
// score_display_scan: four-digit multiplexed seven-segment driver.
// Latches the packed active-low segment word once per scan frame, scans the
// digits onto shared seg/an pins, and optionally blanks leading zeros.
// Build option: define SCORE_DISPLAY_BLINK_EN to blink the anodes while the
// game is in the END state; without it game_state is ignored.
//
// Timing contract: seg and an are registered and show the digit selected by
// idx (and the frame buffer contents) one cycle after idx/fbuf hold them.
// There are no handshakes. display_all is sampled only at the frame boundary.
// lz_blank_en and game_state act on the next edge.
module score_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        game_clk,
    input  logic        rst,
    input  logic [1:0]  game_state,
    input  logic [27:0] display_all,
    input  logic        lz_blank_en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int              CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_ZERO  = 7'b1000000;
    localparam logic [6:0]      SEG_BLANK = 7'b1111111;
    localparam logic [1:0]      ST_END    = 2'd2;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [27:0]   r_fbuf;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic          w_cnt_last;
    logic          w_frame_end;
    logic [6:0]    w_dig0;
    logic [6:0]    w_dig1;
    logic [6:0]    w_dig2;
    logic [6:0]    w_dig3;
    logic          w_blank1;
    logic          w_blank2;
    logic          w_blank3;
    logic [6:0]    w_seg_next;
    logic [3:0]    w_an_scan;
    logic          w_blink_mask;

    assign w_cnt_last  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_cnt_last && (r_idx == 2'd3);

    // Dwell counter and digit index: idx advances once per SCAN_DIV cycles.
    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Frame buffer: capture the score word only at the frame boundary so a
    // frame never mixes digits from two different score values.
    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            r_fbuf <= 28'hFFFFFFF;
        end else if (w_frame_end) begin
            r_fbuf <= display_all;
        end
    end

    assign w_dig0 = r_fbuf[6:0];
    assign w_dig1 = r_fbuf[13:7];
    assign w_dig2 = r_fbuf[20:14];
    assign w_dig3 = r_fbuf[27:21];

    // Leading-zero chain: a digit is blanked only if every digit to its left
    // is blanked too; digit 0 always shows so "0" still reads as zero.
    assign w_blank3 = lz_blank_en && (w_dig3 == SEG_ZERO);
    assign w_blank2 = w_blank3 && (w_dig2 == SEG_ZERO);
    assign w_blank1 = w_blank2 && (w_dig1 == SEG_ZERO);

    // Select the current digit's pattern, replacing it with blank if suppressed.
    always_comb begin
        w_seg_next = SEG_BLANK;
        case (r_idx)
            2'd0: w_seg_next = w_dig0;
            2'd1: w_seg_next = w_blank1 ? SEG_BLANK : w_dig1;
            2'd2: w_seg_next = w_blank2 ? SEG_BLANK : w_dig2;
            2'd3: w_seg_next = w_blank3 ? SEG_BLANK : w_dig3;
            default: w_seg_next = SEG_BLANK;
        endcase
    end

    // One-hot-low anode for the digit currently being scanned.
    always_comb begin
        w_an_scan        = 4'b1111;
        w_an_scan[r_idx] = 1'b0;
    end

`ifdef SCORE_DISPLAY_BLINK_EN
    localparam int            FW         = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] r_frame_cnt;
    logic          r_blink_off;

    // Blink phase: count whole frames in END and flip the phase every
    // BLINK_FRAMES frames; leaving END restarts in the visible phase.
    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (game_state != ST_END) begin
            r_frame_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (w_frame_end) begin
            if (r_frame_cnt == FRAME_LAST) begin
                r_frame_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_frame_cnt <= r_frame_cnt + FW'(1);
            end
        end
    end

    // Gate with the live state so the digits return on the very first edge
    // after END is left, not one cycle later when blink_off clears.
    assign w_blink_mask = r_blink_off && (game_state == ST_END);
`else
    logic w_unused_game_state;

    assign w_unused_game_state = ^game_state;
    assign w_blink_mask        = 1'b0;
`endif

    // Output registers: one cycle behind idx/fbuf, anodes masked during blink-off.
    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_blink_mask ? 4'b1111 : w_an_scan;
            r_seg <= w_seg_next;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = 1'b1;

endmodule
